// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared definitions for the RAM family
//
// Contents:
//   ram_state_e  controller state encoding (ST_INIT, ST_RUN)
//   BYTE_W       bits covered by one byte-enable lane
package ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_e;

endpackage

// File: rtl/sdp_ram_init_seq.sv
// rtl/sdp_ram_init_seq.sv - init sequencer FSM that sweeps INIT_VALUE through the array
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset; restarts the sweep at word 0
//   i_clear      request a new sweep (taken only in ST_RUN)
//   o_init_busy  sweep in progress; user ports must be ignored
//   o_init_we    sweep write strobe into the array mux
//   o_init_addr  word being initialised this cycle
module sdp_ram_init_seq
    import ram_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    output logic                  o_init_busy,
    output logic                  o_init_we,
    output logic [ADDR_WIDTH-1:0] o_init_addr
);

    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(DEPTH - 1);

    ram_state_e            r_state;
    ram_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_ptr;
    logic [ADDR_WIDTH-1:0] w_init_ptr_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_ptr <= w_init_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_ptr_nxt = r_init_ptr;
        o_init_busy    = 1'b0;
        o_init_we      = 1'b0;
        o_init_addr    = r_init_ptr;
        case (r_state)
            ST_INIT: begin
                o_init_busy = 1'b1;
                o_init_we   = 1'b1;
                if (r_init_ptr == LP_LAST) begin
                    w_state_nxt    = ST_RUN;
                    w_init_ptr_nxt = '0;
                end else begin
                    w_init_ptr_nxt = r_init_ptr + 1'b1;
                end
            end
            ST_RUN: begin
                if (i_clear) begin
                    w_state_nxt    = ST_INIT;
                    w_init_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_INIT;
                w_init_ptr_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/sdp_ram_be.sv
// rtl/sdp_ram_be.sv - simple-dual-port RAM with byte enables, registered reads and self-init
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               re-run the init sweep (taken only when idle)
//   wr_en/wr_addr/wr_data/wr_be   write port, wr_be bit i covers wr_data[8i+7:8i]
//   rd_en/rd_addr       read request; result appears one cycle later
//   rd_data, rd_valid   registered read result; out-of-range reads return 0
//   init_busy           init sweep running, all user requests ignored
//
// Build option SDP_RAM_BYPASS_EN: same-address read/write returns the newly
// written word (write-first); otherwise the pre-write contents (read-first).
module sdp_ram_be
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [DATA_WIDTH/BYTE_W-1:0] wr_be,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         init_busy
);

    localparam int                  LP_NB    = DATA_WIDTH / BYTE_W;
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic                  w_init_busy;
    logic                  w_init_we;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic [DATA_WIDTH-1:0] w_wr_old;
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_rd_word;

    sdp_ram_init_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clear     (clear),
        .o_init_busy (w_init_busy),
        .o_init_we   (w_init_we),
        .o_init_addr (w_init_addr)
    );

    assign w_wr_in_range = ({1'b0, wr_addr} < LP_DEPTH);
    assign w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH);
    assign w_wr_old      = w_wr_in_range ? r_mem[wr_addr] : '0;
    assign w_rd_old      = w_rd_in_range ? r_mem[rd_addr] : '0;

    // Full-word read-modify-write: untouched lanes keep their stored bytes.
    always_comb begin
        w_wr_merged = w_wr_old;
        for (int b = 0; b < LP_NB; b++) begin
            if (wr_be[b]) begin
                w_wr_merged[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
            end
        end
    end

    // Init sweep owns the array while busy, so user writes cannot land then.
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= INIT_VALUE;
        end else if (wr_en && w_wr_in_range) begin
            r_mem[wr_addr] <= w_wr_merged;
        end
    end

`ifdef SDP_RAM_BYPASS_EN
    // Same address implies w_wr_old == w_rd_old, so the merged word is the new contents.
    logic w_collide;
    assign w_collide = wr_en && w_wr_in_range && (wr_addr == rd_addr);
    assign w_rd_word = w_collide ? w_wr_merged : w_rd_old;
`else
    assign w_rd_word = w_rd_old;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_init_busy) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign init_busy = w_init_busy;

endmodule

// File: tb/tb_sdp_ram_be.sv
// tb/tb_sdp_ram_be.sv - directed scoreboard bench for sdp_ram_be (DEPTH 64 and DEPTH 48 instances)
module tb_sdp_ram_be;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic [31:0] rd_data, rd_data48;
    logic        rd_valid, rd_valid48;
    logic        init_busy, init_busy48;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model[64];

    always #5 clk = ~clk;

    sdp_ram_be #(
        .DATA_WIDTH (32), .ADDR_WIDTH (6), .DEPTH (64), .INIT_VALUE (32'h0)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .clear (clear),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_be (wr_be),
        .rd_en (rd_en), .rd_addr (rd_addr),
        .rd_data (rd_data), .rd_valid (rd_valid), .init_busy (init_busy)
    );

    sdp_ram_be #(
        .DATA_WIDTH (32), .ADDR_WIDTH (6), .DEPTH (48), .INIT_VALUE (32'h0)
    ) u_dut48 (
        .clk (clk), .rst_n (rst_n), .clear (clear),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_be (wr_be),
        .rd_en (rd_en), .rd_addr (rd_addr),
        .rd_data (rd_data48), .rd_valid (rd_valid48), .init_busy (init_busy48)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic pop_check();
        exp_t e;
        e = exp_q.pop_front();
        check({e.tag, "_valid"}, {31'b0, rd_valid}, 32'h1);
        check(e.tag, rd_data, e.data);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
        model_write(a, d, be);
    endtask

    task automatic rd(input logic [5:0] a, input string tag);
        rd_en = 1'b1; rd_addr = a;
        exp_q.push_back('{tag, model[a]});
        tick();
        rd_en = 1'b0;
        pop_check();
    endtask

    task automatic collide(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be, input string tag);
        logic [31:0] nw;
        nw = model[a];
        for (int b = 0; b < 4; b++) if (be[b]) nw[b*8 +: 8] = d[b*8 +: 8];
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        rd_en = 1'b1; rd_addr = a;
`ifdef SDP_RAM_BYPASS_EN
        exp_q.push_back('{tag, nw});
`else
        exp_q.push_back('{tag, model[a]});
`endif
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        model[a] = nw;
        pop_check();
    endtask

    // Counts busy samples for both instances from sample index 'start'; also
    // flags any rd_valid seen while the corresponding instance is busy.
    task automatic wait_init(input int start, input string tag);
        int n, n64, n48, bad;
        n = start; n64 = -1; n48 = -1; bad = 0;
        while (n < 300) begin
            if (init_busy && rd_valid) bad++;
            if (init_busy48 && rd_valid48) bad++;
            if (!init_busy && n64 < 0) n64 = n;
            if (!init_busy48 && n48 < 0) n48 = n;
            if (n64 >= 0 && n48 >= 0) break;
            n++;
            tick();
        end
        check({tag, "_busy64"}, n64, 32'd64);
        check({tag, "_busy48"}, n48, 32'd48);
        check({tag, "_valid_during_busy"}, bad, 32'd0);
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        #1 rst_n = 1'b0;
        tick(); tick();
        check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_busy", {31'b0, init_busy}, 32'h1);
        check("rst_busy48", {31'b0, init_busy48}, 32'h1);

        // 1: initial sweep, reads of first/middle/last word
        rst_n = 1'b1;
        wait_init(0, "t1");
        rd(6'd0, "t1_rd0");
        rd(6'd31, "t1_rd31");
        rd(6'd63, "t1_rd63");

        // 2: byte-enable merge, no-op with be=0, hold when idle
        wr(6'd5, 32'hAABBCCDD, 4'hF);
        wr(6'd5, 32'h00001100, 4'b0010);
        rd(6'd5, "t2_rd5");
        tick();
        check("t2_idle_valid", {31'b0, rd_valid}, 32'h0);
        check("t2_idle_hold", rd_data, 32'hAABB11DD);
        wr(6'd5, 32'hFFFFFFFF, 4'h0);
        rd(6'd5, "t2_be0_rd5");

        // 3: same-address read/write collision
        collide(6'd7, 32'h12345678, 4'hF, "t3_col_full");
        rd(6'd7, "t3_after");
        collide(6'd7, 32'h000000AA, 4'b0001, "t3_col_part");
        rd(6'd7, "t3_after_part");

        // 4: clear with traffic in the clear cycle, then poll during sweep
        wr(6'd10, 32'h01020304, 4'hF);
        wr(6'd63, 32'hDEADBEEF, 4'hF);
        rd(6'd63, "t4_pre63");
        clear = 1'b1;
        wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'h99999999; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 6'd5;
        exp_q.push_back('{"t4_clear_cycle_rd", model[5]});
        tick();
        clear = 1'b0; wr_en = 1'b0;
        pop_check();
        check("t4_busy_after_clear", {31'b0, init_busy}, 32'h1);
        rd_addr = 6'd3;
        tick();
        wait_init(1, "t4");
        rd_en = 1'b0;
        for (int a = 0; a < 64; a++) rd(6'(a), $sformatf("t4_zero%0d", a));

        // 5: reset mid-read, then reset mid-sweep
        wr(6'd7, 32'hCAFEF00D, 4'hF);
        rd_en = 1'b1; rd_addr = 6'd7;
        exp_q.push_back('{"t5_rd7", model[7]});
        tick();
        rd_en = 1'b0;
        pop_check();
        rst_n = 1'b0;
        #1;
        check("t5_rdrst_valid", {31'b0, rd_valid}, 32'h0);
        check("t5_rdrst_data", rd_data, 32'h0);
        check("t5_rdrst_busy", {31'b0, init_busy}, 32'h1);
        tick();
        rst_n = 1'b1;
        wait_init(0, "t5a");
        wr(6'd7, 32'h5A5A5A5A, 4'hF);
        rd(6'd7, "t5_rd7b");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check("t5_initrst_busy", {31'b0, init_busy}, 32'h1);
        check("t5_initrst_valid", {31'b0, rd_valid}, 32'h0);
        check("t5_initrst_data", rd_data, 32'h0);
        tick();
        rst_n = 1'b1;
        wait_init(0, "t5b");
        rd(6'd7, "t5_rd7_after");

        // 6: DEPTH=48 instance boundary behaviour
        wr(6'd50, 32'h50505050, 4'hF);
        rd(6'd50, "t6_d64_rd50");
        check("t6_d48_valid50", {31'b0, rd_valid48}, 32'h1);
        check("t6_d48_rd50", rd_data48, 32'h0);
        wr(6'd47, 32'h47474747, 4'hF);
        rd(6'd47, "t6_d64_rd47");
        check("t6_d48_valid47", {31'b0, rd_valid48}, 32'h1);
        check("t6_d48_rd47", rd_data48, 32'h47474747);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
